// File: rtl/game_pkg.sv
// Shared encodings and button rectangles for the game sequencer and overlay.
package game_pkg;

    localparam logic [3:0] S_TITLE    = 4'd0;
    localparam logic [3:0] S_STAFF    = 4'd1;
    localparam logic [3:0] S_STAGE1   = 4'd2;
    localparam logic [3:0] S_SUCCESS1 = 4'd3;
    localparam logic [3:0] S_STAGE2   = 4'd4;
    localparam logic [3:0] S_SUCCESS2 = 4'd5;
    localparam logic [3:0] S_STAGE3   = 4'd6;
    localparam logic [3:0] S_SUCCESS3 = 4'd7;
    localparam logic [3:0] S_FAIL     = 4'd8;
    localparam logic [3:0] S_HELP     = 4'd9;

    localparam logic [1:0] TD_NONE  = 2'd0;
    localparam logic [1:0] TD_KEY   = 2'd1;
    localparam logic [1:0] TD_LIGHT = 2'd2;
    localparam logic [1:0] TD_DOOR  = 2'd3;

    localparam logic [8:0] BTN_X0 = 9'd120;
    localparam logic [8:0] BTN_X1 = 9'd200;

    localparam logic [8:0] T_S1_Y0 = 9'd120;
    localparam logic [8:0] T_S1_Y1 = 9'd140;
    localparam logic [8:0] T_S2_Y0 = 9'd150;
    localparam logic [8:0] T_S2_Y1 = 9'd170;
    localparam logic [8:0] T_S3_Y0 = 9'd180;
    localparam logic [8:0] T_S3_Y1 = 9'd200;
    localparam logic [8:0] T_HP_Y0 = 9'd210;
    localparam logic [8:0] T_HP_Y1 = 9'd230;

    localparam logic [8:0] NEXT_Y0 = 9'd140;
    localparam logic [8:0] NEXT_Y1 = 9'd160;
    localparam logic [8:0] BACK_Y0 = 9'd180;
    localparam logic [8:0] BACK_Y1 = 9'd200;
    localparam logic [8:0] STF_Y0  = 9'd150;
    localparam logic [8:0] STF_Y1  = 9'd170;
    localparam logic [8:0] HLP_Y0  = 9'd200;
    localparam logic [8:0] HLP_Y1  = 9'd220;

    function automatic logic in_row(
        input logic [8:0] x,
        input logic [8:0] y,
        input logic [8:0] y0,
        input logic [8:0] y1
    );
        return (x >= BTN_X0) && (x < BTN_X1) &&
               (y >= y0) && (y < y1);
    endfunction

    function automatic logic is_stage(input logic [3:0] s);
        return (s == S_STAGE1) || (s == S_STAGE2) ||
               (s == S_STAGE3);
    endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Cursor/event inputs and HUD outputs between stage logic, sequencer and renderer.
interface game_flow_ctrl_if;

    logic       click;
    logic [8:0] cur_x;
    logic [8:0] cur_y;
    logic       ev_key;
    logic       ev_light;
    logic       ev_door;
    logic       ev_hit;
    logic [3:0] state;
    logic [1:0] key_find;
    logic [1:0] life;
    logic [1:0] todo;
    logic [3:0] play_valid;
    logic       stage_init;

    modport master (
        output click, cur_x, cur_y,
        output ev_key, ev_light, ev_door, ev_hit,
        input  state, key_find, life, todo,
        input  play_valid, stage_init
    );

    modport slave (
        input  click, cur_x, cur_y,
        input  ev_key, ev_light, ev_door, ev_hit,
        output state, key_find, life, todo,
        output play_valid, stage_init
    );

endinterface

// File: rtl/click_edge.sv
// Click rising-edge detector; coords are registered alongside the click level.
module click_edge (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       click,
    input  logic [8:0] cur_x,
    input  logic [8:0] cur_y,
    output logic       rise,
    output logic [8:0] x,
    output logic [8:0] y
);

    logic click_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            click_q <= 1'b0;
            x       <= '0;
            y       <= '0;
        end else begin
            click_q <= click;
            x       <= cur_x;
            y       <= cur_y;
        end
    end

    assign rise = click & ~click_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Screen-state sequencer and HUD status for the overlay renderer.
// UNLOCK_ALL_EN: all stages selectable from TITLE out of reset.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int HIT_COOLDOWN = 50_000_000,
    parameter int START_LIFE   = 3
) (
    input logic         clk,
    input logic         rst_n,
    game_flow_ctrl_if.slave bus
);

    localparam int CW = (HIT_COOLDOWN > 1) ? $clog2(HIT_COOLDOWN) : 1;
    localparam logic [CW-1:0] COOL_LOAD = CW'(HIT_COOLDOWN - 1);
`ifdef UNLOCK_ALL_EN
    localparam logic [3:0] PV_RST = 4'b1110;
`else
    localparam logic [3:0] PV_RST = 4'b0010;
`endif

    logic [3:0]    state_q, nxt;
    logic [1:0]    key_q, life_q, todo_q;
    logic [3:0]    pv_q;
    logic          init_q;
    logic [CW-1:0] cool_q;
    logic          rise;
    logic [8:0]    bx, by;
    logic          in_stage, entering;
    logic          key_ok, light_ok, door_ok, hit_ok;

    click_edge u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .click (bus.click),
        .cur_x (bus.cur_x),
        .cur_y (bus.cur_y),
        .rise  (rise),
        .x     (bx),
        .y     (by)
    );

    assign in_stage = is_stage(state_q);
    assign key_ok   = in_stage && bus.ev_key && (todo_q == TD_KEY);
    assign light_ok = in_stage && bus.ev_light && (todo_q == TD_LIGHT);
    assign door_ok  = in_stage && bus.ev_door && (todo_q == TD_DOOR);
    // a door exit in the same cycle shields the player from damage
    assign hit_ok   = (state_q == S_STAGE3) && bus.ev_hit &&
                      (cool_q == '0) && !door_ok && (life_q != 2'd0);
    assign entering = is_stage(nxt) && (nxt != state_q);

    always_comb begin
        nxt = state_q;
        case (state_q)
            S_TITLE: if (rise) begin
                if (in_row(bx, by, T_S1_Y0, T_S1_Y1))
                    nxt = S_STAGE1;
                else if (in_row(bx, by, T_S2_Y0, T_S2_Y1) && pv_q[2])
                    nxt = S_STAGE2;
                else if (in_row(bx, by, T_S3_Y0, T_S3_Y1) && pv_q[3])
                    nxt = S_STAGE3;
                else if (in_row(bx, by, T_HP_Y0, T_HP_Y1))
                    nxt = S_HELP;
            end
            S_STAGE1: if (door_ok) nxt = S_SUCCESS1;
            S_STAGE2: if (door_ok) nxt = S_SUCCESS2;
            S_STAGE3: begin
                if (door_ok)
                    nxt = S_SUCCESS3;
                else if (hit_ok && life_q == 2'd1)
                    nxt = S_FAIL;
            end
            S_SUCCESS1: if (rise) begin
                if (in_row(bx, by, NEXT_Y0, NEXT_Y1))
                    nxt = S_STAGE2;
                else if (in_row(bx, by, BACK_Y0, BACK_Y1))
                    nxt = S_TITLE;
            end
            S_SUCCESS2: if (rise) begin
                if (in_row(bx, by, NEXT_Y0, NEXT_Y1))
                    nxt = S_STAGE3;
                else if (in_row(bx, by, BACK_Y0, BACK_Y1))
                    nxt = S_TITLE;
            end
            S_SUCCESS3: if (rise && in_row(bx, by, STF_Y0, STF_Y1))
                nxt = S_STAFF;
            S_FAIL: if (rise) begin
                if (in_row(bx, by, NEXT_Y0, NEXT_Y1))
                    nxt = S_STAGE3;
                else if (in_row(bx, by, BACK_Y0, BACK_Y1))
                    nxt = S_TITLE;
            end
            S_STAFF: if (rise && in_row(bx, by, BACK_Y0, BACK_Y1))
                nxt = S_TITLE;
            S_HELP: if (rise && in_row(bx, by, HLP_Y0, HLP_Y1))
                nxt = S_TITLE;
            default: nxt = S_TITLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_TITLE;
            init_q  <= 1'b0;
        end else begin
            state_q <= nxt;
            init_q  <= entering;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q  <= 2'd0;
            life_q <= 2'd0;
            todo_q <= TD_NONE;
            pv_q   <= PV_RST;
            cool_q <= '0;
        end else begin
            if (entering) begin
                key_q  <= 2'd0;
                todo_q <= (nxt == S_STAGE2) ? TD_LIGHT : TD_KEY;
                life_q <= (nxt == S_STAGE3) ? 2'(START_LIFE) : 2'd0;
                cool_q <= '0;
            end else begin
                if (cool_q != '0)
                    cool_q <= cool_q - 1'b1;
                if (light_ok)
                    todo_q <= TD_KEY;
                if (key_ok && key_q != 2'd3) begin
                    key_q <= key_q + 2'd1;
                    if (key_q == 2'd2)
                        todo_q <= TD_DOOR;
                end
                if (hit_ok) begin
                    life_q <= life_q - 2'd1;
                    cool_q <= COOL_LOAD;
                end
            end
            if (nxt == S_SUCCESS1 && state_q != S_SUCCESS1)
                pv_q[2] <= 1'b1;
            if (nxt == S_SUCCESS2 && state_q != S_SUCCESS2)
                pv_q[3] <= 1'b1;
        end
    end

    assign bus.state      = state_q;
    assign bus.key_find   = key_q;
    assign bus.life       = life_q;
    assign bus.todo       = todo_q;
    assign bus.play_valid = pv_q;
    assign bus.stage_init = init_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed-vector bench for game_flow_ctrl (HIT_COOLDOWN=4).
module tb_game_flow_ctrl;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    game_flow_ctrl_if bus ();

    game_flow_ctrl #(
        .HIT_COOLDOWN (4),
        .START_LIFE   (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // mask = {hit, door, light, key}
    task automatic pulse(input logic [3:0] m);
        bus.ev_key   = m[0];
        bus.ev_light = m[1];
        bus.ev_door  = m[2];
        bus.ev_hit   = m[3];
        step();
        bus.ev_key   = 1'b0;
        bus.ev_light = 1'b0;
        bus.ev_door  = 1'b0;
        bus.ev_hit   = 1'b0;
    endtask

    // Leaves the sampling point just after the edge that acted on the rise.
    task automatic click_at(input int x, input int y);
        bus.cur_x = 9'(x);
        bus.cur_y = 9'(y);
        step();
        bus.click = 1'b1;
        step();
        bus.click = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.click = 1'b0;
        bus.cur_x = '0;
        bus.cur_y = '0;
        bus.ev_key = 1'b0;
        bus.ev_light = 1'b0;
        bus.ev_door = 1'b0;
        bus.ev_hit = 1'b0;
        step(2);
        chk("rst_state", bus.state, 0);
        chk("rst_key", bus.key_find, 0);
        chk("rst_life", bus.life, 0);
        chk("rst_todo", bus.todo, 0);
        chk("rst_pv", bus.play_valid, 4'b0010);
        chk("rst_init", bus.stage_init, 0);
        rst_n = 1'b1;
        step();

        click_at(150, 160);
        chk("locked_s2", bus.state, 0);
        step();
        click_at(100, 130);
        chk("outside_btn", bus.state, 0);
        step();
        click_at(150, 220);
        chk("help", bus.state, 9);
        step();
        click_at(150, 210);
        chk("help_back", bus.state, 0);
        step();

        click_at(150, 130);
        chk("s1_state", bus.state, 2);
        chk("s1_init", bus.stage_init, 1);
        chk("s1_todo", bus.todo, 1);
        chk("s1_key", bus.key_find, 0);
        step();
        chk("s1_init_off", bus.stage_init, 0);

        pulse(4'b0100);
        chk("s1_early_door", bus.state, 2);
        pulse(4'b0001);
        pulse(4'b0001);
        chk("s1_key2", bus.key_find, 2);
        pulse(4'b0001);
        chk("s1_key3", bus.key_find, 3);
        chk("s1_todo_door", bus.todo, 3);
        pulse(4'b0001);
        chk("s1_key_sat", bus.key_find, 3);
        pulse(4'b0100);
        chk("s1_success", bus.state, 3);
        chk("s1_unlock", bus.play_valid, 4'b0110);

        click_at(150, 190);
        chk("succ1_title", bus.state, 0);
        step();
        click_at(150, 160);
        chk("s2_state", bus.state, 4);
        chk("s2_todo", bus.todo, 2);
        step();
        pulse(4'b0001);
        chk("s2_key_early", bus.key_find, 0);
        pulse(4'b0010);
        chk("s2_light", bus.todo, 1);
        pulse(4'b0001);
        chk("s2_key1", bus.key_find, 1);
        pulse(4'b0001);
        pulse(4'b0001);
        chk("s2_todo_door", bus.todo, 3);
        pulse(4'b0100);
        chk("s2_success", bus.state, 5);
        chk("s2_unlock", bus.play_valid, 4'b1110);

        click_at(150, 150);
        chk("s3_state", bus.state, 6);
        chk("s3_life", bus.life, 3);
        chk("s3_init", bus.stage_init, 1);
        step();
        pulse(4'b1000);
        step();
        pulse(4'b1000);
        chk("s3_cooldown", bus.life, 2);
        step(4);
        pulse(4'b1000);
        chk("s3_hit2", bus.life, 1);
        step(4);
        pulse(4'b1000);
        chk("s3_life0", bus.life, 0);
        chk("s3_fail", bus.state, 8);

        click_at(150, 150);
        chk("retry_state", bus.state, 6);
        chk("retry_life", bus.life, 3);
        step();
        pulse(4'b0001);
        pulse(4'b0001);
        pulse(4'b0101);
        chk("keydoor_key", bus.key_find, 3);
        chk("keydoor_state", bus.state, 6);
        pulse(4'b1100);
        chk("doorhit_state", bus.state, 7);
        chk("doorhit_life", bus.life, 3);

        click_at(150, 160);
        chk("staff", bus.state, 1);
        step();
        bus.cur_x = 9'd150;
        bus.cur_y = 9'd190;
        step();
        bus.click = 1'b1;
        step(10);
        chk("held_click", bus.state, 0);
        bus.click = 1'b0;
        step();

        click_at(150, 190);
        chk("s3_direct", bus.state, 6);
        step();
        pulse(4'b0001);
        chk("mid_key", bus.key_find, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", bus.state, 0);
        chk("arst_key", bus.key_find, 0);
        chk("arst_life", bus.life, 0);
        chk("arst_todo", bus.todo, 0);
        chk("arst_pv", bus.play_valid, 4'b0010);
        chk("arst_init", bus.stage_init, 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
